// File: rtl/tt_um_lfsr_sachin.sv
// tt_um_lfsr_sachin: TinyTapeout tile with a 16-bit Galois LFSR and an optional 8-bit low-byte mode
// Ports:
//   clk     - rising-edge clock
//   rst_n   - synchronous reset, active HIGH despite the name; loads 0xACE1
//   ena     - tile select, unused
//   ui_in   - [0] run, [1] step, [2] load_lo, [3] load_hi, [4] out_sel, [5] mode8
//   uio_in  - seed byte for loads
//   uo_out  - selected LFSR byte (high when out_sel, else low)
//   uio_out - tied to 0
//   uio_oe  - tied to 0 (bidirectional pins are inputs)
module tt_um_lfsr_sachin (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [15:0] s_q, s_d, nxt16;
    logic [7:0]  nxt8;
    logic        step_q, adv, load;
    logic        unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:6]};
    // a step counts only on a 0->1 transition seen across consecutive edges
    assign adv  = ui_in[0] | (ui_in[1] & ~step_q);
    assign load = ui_in[2] | ui_in[3];
    always_comb begin
        // all-zero state would lock the LFSR, so it reseeds to 1
        nxt16 = (s_q == 16'h0) ? 16'h0001 : ((s_q >> 1) ^ (s_q[0] ? 16'hB400 : 16'h0000));
        nxt8  = (s_q[7:0] == 8'h0) ? 8'h01 : ((s_q[7:0] >> 1) ^ (s_q[0] ? 8'hB8 : 8'h00));
        s_d   = load ? {ui_in[3] ? uio_in : s_q[15:8], ui_in[2] ? uio_in : s_q[7:0]}
              : adv  ? (ui_in[5] ? {s_q[15:8], nxt8} : nxt16)
              : s_q;
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s_q    <= 16'hACE1;
            step_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            step_q <= ui_in[1];
        end
    end
    assign uo_out  = ui_in[4] ? s_q[15:8] : s_q[7:0];
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_lfsr_sachin.sv
// tb_tt_um_lfsr_sachin: directed self-checking bench for the LFSR tile
module tb_tt_um_lfsr_sachin;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    int checks = 0;
    int errors = 0;
    localparam logic [7:0] RUN = 8'h01, STEP = 8'h02, LLO = 8'h04, LHI = 8'h08, OSEL = 8'h10, M8 = 8'h20;
    tt_um_lfsr_sachin dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic check_s(input string tag, input logic [15:0] exp);
        logic sel;
        sel = ui_in[4];
        ui_in[4] = 1'b0;
        #1 check({tag, "_lo"}, uo_out, exp[7:0]);
        ui_in[4] = 1'b1;
        #1 check({tag, "_hi"}, uo_out, exp[15:8]);
        ui_in[4] = sel;
        #1;
    endtask
    logic [15:0] seq16 [6] = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
    logic [7:0]  seq8  [4] = '{8'hC8, 8'h64, 8'h32, 8'h19};
    initial begin
        rst_n = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        tick(); tick();
        check_s("reset", 16'hACE1);
        check("uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'h00);
        // free run, 16-bit; first advance on the edge that samples reset released
        rst_n = 1'b0; ui_in = RUN;
        foreach (seq16[i]) begin
            tick();
            if (i == 0) begin
                ui_in = RUN | OSEL;
                #1 check("osel_same_cycle", uo_out, 8'hE2);
                ui_in = RUN;
            end
            check_s($sformatf("run16_%0d", i), seq16[i]);
        end
        rst_n = 1'b1; tick();
        check_s("reset_mid_run", 16'hACE1);
        // step mode: held step gives exactly one advance
        rst_n = 1'b0; ui_in = STEP;
        repeat (5) tick();
        check_s("step_hold", 16'hE270);
        ui_in = 8'h00; tick();
        check_s("step_low", 16'hE270);
        ui_in = STEP; tick();
        check_s("step_again", 16'h7138);
        // zero load and lock-up guard
        ui_in = LLO | LHI; uio_in = 8'h00; tick();
        check_s("load_zero", 16'h0000);
        ui_in = RUN; tick();
        check_s("guard16", 16'h0001);
        tick();
        check_s("after_guard16", 16'hB400);
        // step edge coinciding with a load is consumed
        ui_in = 8'h00; tick();
        ui_in = STEP | LLO; uio_in = 8'h33; tick();
        check_s("load_step", 16'hB433);
        ui_in = STEP; tick();
        check_s("step_consumed", 16'hB433);
        // load beats run
        rst_n = 1'b1; tick();
        rst_n = 1'b0; ui_in = RUN | LHI; uio_in = 8'h5A; tick();
        check_s("load_over_run", 16'h5AE1);
        // 8-bit mode
        rst_n = 1'b1; tick();
        rst_n = 1'b0; ui_in = RUN | M8;
        foreach (seq8[i]) begin
            tick();
            check_s($sformatf("run8_%0d", i), {8'hAC, seq8[i]});
        end
        ui_in = LLO | M8; uio_in = 8'h00; tick();
        check_s("load_lo_zero", 16'hAC00);
        ui_in = RUN | M8; tick();
        check_s("guard8", 16'hAC01);
        tick();
        check_s("after_guard8", 16'hACB8);
        // mode8 toggle alone leaves state untouched
        ui_in = 8'h00; tick();
        check_s("mode_switch_hold", 16'hACB8);
        // periods
        rst_n = 1'b1; tick();
        rst_n = 1'b0; ui_in = RUN;
        repeat (65534) tick();
        ui_in = 8'h00;
        #1 check("period16_not_early", (uo_out == 8'hE1) ? 8'h01 : 8'h00, 8'h00);
        ui_in = RUN; tick();
        ui_in = 8'h00;
        check_s("period16", 16'hACE1);
        rst_n = 1'b1; tick();
        rst_n = 1'b0; ui_in = RUN | M8;
        repeat (255) tick();
        ui_in = M8;
        check_s("period8", 16'hACE1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
